load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle datapath, between its ALUResult/WriteData outputs and the data memory bus.
- Converts each load/store into a valid/grant/rvalid bus transaction with byte enables.
- Returns aligned, sign- or zero-extended ReadData to the datapath.
- Stalls the core while the bus has wait states; flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT, 255, max cycles spent in REQ+RSP before abort (8-bit counter; must be 1..255)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- mem_read  input  1  load request from control unit
- mem_write  input  1  store request from control unit
- funct3  input  3  Instr[14:12]; access size/sign
- addr  input  32  byte address (datapath ALUResult)
- wdata  input  32  store data (datapath WriteData)
- rdata  output  32  formatted load data (to datapath ReadData)
- stall  output  1  core must hold PC and suppress register writes
- fault  output  1  one-cycle pulse: misaligned/illegal/timeout
- bus_req  output  1  bus request valid
- bus_we  output  1  1=write, 0=read
- bus_addr  output  32  word address, {addr[31:2],2'b00}
- bus_wdata  output  32  lane-replicated store data
- bus_be  output  4  byte enables
- bus_gnt  input  1  request accepted this cycle
- bus_rvalid  input  1  read data valid
- bus_rdata  input  32  read data

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on port reset.
- Reset effects:
  - state=IDLE; rdata, fault, bus_req, bus_we, bus_addr, bus_wdata, bus_be and counter all 0.
  - A transaction in flight is abandoned; bus_req drops at that edge.
- Request rules:
  - req = mem_read|mem_write. If both are asserted, the access is a write.
- Legality:
  - funct3 loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
- Stall:
  - stall = (IDLE & req & legal & aligned) | REQ | RSP. Combinational, so it is asserted in the first cycle of the request.
- IDLE:
  - On req & legal & aligned: latch addr, wdata, funct3 and direction; clear counter; go to REQ.
  - On req & (illegal | misaligned): fault=1 for the next cycle, no bus activity, stall=0, rdata unchanged; go to DONE.
- REQ:
  - bus_req=1, held with stable address/data/be until bus_gnt.
  - Store: on gnt go to DONE (posted write).
  - Load: on gnt go to RSP. If bus_rvalid is also high that cycle, capture bus_rdata and go to DONE.
- RSP:
  - bus_req=0. On bus_rvalid, capture and format data into rdata; go to DONE.
- Timeout:
  - Counter increments each cycle in REQ/RSP.
  - On reaching TIMEOUT: bus_req=0, fault=1 next cycle, rdata=0 for a load; go to DONE.
- DONE:
  - stall=0 for one cycle; the core retires the instruction at this edge.
  - Always returns to IDLE. No new request is accepted in DONE, because the same instruction is still presented.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - SW: be=1111.
- Load formatting:
  - Select the byte/halfword by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- rdata hold: rdata is registered and holds its value until the next load completion or reset.
- Ignored inputs: bus_rvalid outside REQ/RSP, and bus_gnt outside REQ.

Test Plan:
- LB at addr 0x1003; bus_rdata=0x80FF_0000; gnt and rvalid one cycle later -> bus_be=1111 on read, rdata=0xFFFF_FF80, stall high 2 cycles then low in DONE.
- SH at addr 0x2002, wdata=0x0000_ABCD; gnt after 3 wait cycles -> bus_req high 4 cycles, bus_be=1100, bus_wdata=0xABCD_ABCD, bus_addr=0x2000, bus_we=1.
- LW at addr 0x3001 -> no bus_req, fault pulses one cycle, stall=0, rdata unchanged.
- LHU at addr 0x4002, TIMEOUT=4, bus_gnt never asserted -> bus_req drops after 4 cycles, fault=1, rdata=0, FSM returns to IDLE.
- Load with gnt and rvalid in the same cycle, bus_rdata=0x1234_5678, LW -> rdata=0x1234_5678, no RSP state visited.
- reset asserted while in RSP -> bus_req/stall/rdata all 0 after the edge; a following SW at 0x10 with immediate gnt completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
//   Data memory bus between the load/store unit and data memory.
//   Handshake: the master raises bus_req with a stable address/data/byte
//   enables until bus_gnt is seen. Reads complete when bus_rvalid returns
//   bus_rdata, which may be in the same cycle as bus_gnt.
//
//   bus_req    master -> slave  request valid
//   bus_we     master -> slave  1 = write, 0 = read
//   bus_addr   master -> slave  word-aligned byte address
//   bus_wdata  master -> slave  store data, replicated across byte lanes
//   bus_be     master -> slave  byte enables
//   bus_gnt    slave -> master  request accepted this cycle
//   bus_rvalid slave -> master  read data valid
//   bus_rdata  slave -> master  read data
// ----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//   Sits between the single-cycle datapath (ALUResult / WriteData) and the
//   data memory bus. Each load or store becomes one bus transaction with byte
//   enables; load data is aligned and sign/zero-extended before being handed
//   back. The core is stalled while the bus inserts wait states, and
//   misaligned, illegal or timed-out accesses raise a one-cycle fault.
//
//   Parameter TIMEOUT : cycles allowed in REQ+RSP before abort (1..255)
//
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   mem_read   in   load request
//   mem_write  in   store request (wins when both are asserted)
//   funct3     in   access size / signedness (Instr[14:12])
//   addr       in   byte address
//   wdata      in   store data
//   rdata      out  formatted load data, held until the next load completes
//   stall      out  core must hold PC and suppress register writes
//   fault      out  one-cycle pulse on misaligned/illegal/timeout
//   bus        master side of load_store_unit_if
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [2:0]                funct3,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata,
    output logic                      stall,
    output logic                      fault,
    load_store_unit_if.master         bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The counter holds the number of REQ/RSP cycles already spent, so the
    // abort happens in the cycle where it equals TIMEOUT-1 (the TIMEOUT-th
    // cycle). TIMEOUT must stay within 1..255 to fit the 8-bit counter.
    localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic        lat_we;

    logic        req;
    logic        is_write;
    logic        legal;
    logic        aligned;
    logic        start;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    // Selects the addressed byte/halfword of a bus word and extends it.
    // Word accesses are always aligned, so the shift is zero for them.
    function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] data);
        logic [31:0] shifted;
        shifted = data >> {off, 3'b000};
        case (f3)
            3'b000:  format_load = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  format_load = {24'b0, shifted[7:0]};
            3'b001:  format_load = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  format_load = {16'b0, shifted[15:0]};
            default: format_load = shifted;
        endcase
    endfunction

    // Request decode: legality depends on direction, alignment on size only.
    always_comb begin
        req      = mem_read | mem_write;
        is_write = mem_write;
        legal    = 1'b0;
        aligned  = 1'b1;
        case (funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~is_write;
            default:                legal = 1'b0;
        endcase
        case (funct3[1:0])
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        start = (state == IDLE) & req & legal & aligned;
        stall = start | (state == REQ) | (state == RSP);
    end

    // Store lane steering. Loads always fetch the whole word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata;
        if (is_write) begin
            case (funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << addr[1:0];
                    st_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << addr[1:0];
                    st_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = wdata;
                end
            endcase
        end
    end

    // Transaction FSM with registered bus outputs. A completing handshake
    // takes priority over the timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            rdata         <= 32'd0;
            fault         <= 1'b0;
            lat_funct3    <= 3'd0;
            lat_off       <= 2'd0;
            lat_we        <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_wdata <= 32'd0;
            bus.bus_be    <= 4'd0;
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (legal && aligned) begin
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= is_write;
                            bus.bus_addr  <= {addr[31:2], 2'b00};
                            bus.bus_be    <= st_be;
                            bus.bus_wdata <= st_wdata;
                            lat_funct3    <= funct3;
                            lat_off       <= addr[1:0];
                            lat_we        <= is_write;
                            cnt           <= 8'd0;
                            state         <= REQ;
                        end else begin
                            fault <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_gnt && (lat_we || bus.bus_rvalid)) begin
                        if (!lat_we) begin
                            rdata <= format_load(lat_funct3, lat_off, bus.bus_rdata);
                        end
                        bus.bus_req <= 1'b0;
                        state       <= DONE;
                    end else if (cnt == LAST_CYCLE) begin
                        if (!lat_we) begin
                            rdata <= 32'd0;
                        end
                        bus.bus_req <= 1'b0;
                        fault       <= 1'b1;
                        state       <= DONE;
                    end else if (bus.bus_gnt) begin
                        bus.bus_req <= 1'b0;
                        cnt         <= cnt + 8'd1;
                        state       <= RSP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RSP: begin
                    if (bus.bus_rvalid) begin
                        rdata <= format_load(lat_funct3, lat_off, bus.bus_rdata);
                        state <= DONE;
                    end else if (cnt == LAST_CYCLE) begin
                        rdata <= 32'd0;
                        fault <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    // The retiring instruction is still on the inputs here,
                    // so it must not be accepted a second time.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
